// File: rtl/dispatch_alloc_nway.sv
// dispatch_alloc_nway: in-order multi-lane dispatch allocator.
// Hands each granted lane a free reservation-buffer slot, a decrementing
// sequence tag and a speculative-tag mask, and maintains the live
// speculative-bit pool together with per-bit branch dependency rows.
module dispatch_alloc_nway #(
    parameter int WIDTH        = 2,
    parameter int BUF_SIZE     = 16,
    parameter int BUF_SIZE_LOG = 4,
    parameter int NSPEC        = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              in_valid,
    input  logic [WIDTH-1:0]              in_is_branch,
    input  logic [BUF_SIZE-1:0]           buf_free,
    output logic [WIDTH-1:0]              grant,
    output logic [WIDTH*BUF_SIZE_LOG-1:0] alloc_idx,
    output logic [WIDTH*BUF_SIZE_LOG-1:0] alloc_tag,
    output logic [WIDTH*NSPEC-1:0]        alloc_spectag,
    input  logic                          br_valid,
    input  logic [NSPEC-1:0]              br_bit,
    input  logic                          br_mispredict,
    output logic [NSPEC-1:0]              squash_mask,
    output logic [NSPEC-1:0]              live_mask
);

    localparam int LW = BUF_SIZE_LOG;

    // Index of the lowest set bit of a free-slot vector (0 when none set).
    function automatic logic [LW-1:0] lowest_free_slot(input logic [BUF_SIZE-1:0] v);
        logic [LW-1:0] idx;
        logic          found;
        idx   = {LW{1'b0}};
        found = 1'b0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            if (v[i] && !found) begin
                idx   = LW'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // One-hot of the lowest clear bit of a spec-bit usage vector (0 when full).
    function automatic logic [NSPEC-1:0] lowest_clear_onehot(input logic [NSPEC-1:0] used);
        logic [NSPEC-1:0] oh;
        logic             found;
        oh    = {NSPEC{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NSPEC; i++) begin
            if (!used[i] && !found) begin
                oh[i] = 1'b1;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return oh;
    endfunction

    logic [NSPEC-1:0]    live_r;
    logic [NSPEC-1:0]    dep_r [NSPEC];
    logic [LW-1:0]       tag_r;

    logic                br_hit_s;
    logic                mispredict_s;
    logic [NSPEC-1:0]    squash_s;
    logic [NSPEC-1:0]    clear_s;
    logic [NSPEC-1:0]    alloc_bits_s;
    logic [NSPEC-1:0]    dep_new_s [NSPEC];
    logic [LW-1:0]       next_tag_s;

    assign live_mask   = live_r;
    assign squash_mask = squash_s;

    // Branch resolution: work out which live bits die this cycle and whether grants are blocked.
    always_comb begin
        logic [NSPEC-1:0] sq_v;
        sq_v = br_bit;
        for (int c = 0; c < NSPEC; c++) begin
            if (|(dep_r[c] & br_bit)) begin
                sq_v[c] = 1'b1;
            end else begin
                sq_v[c] = sq_v[c];
            end
        end
        // A resolution naming a bit that is not live is ignored entirely.
        br_hit_s     = br_valid & (|(br_bit & live_r)) & ~reset;
        mispredict_s = br_hit_s & br_mispredict;
        if (mispredict_s) begin
            // Stale dependency rows of already-freed bits are masked off by live_r.
            squash_s = sq_v & live_r;
            clear_s  = sq_v & live_r;
        end else if (br_hit_s) begin
            squash_s = {NSPEC{1'b0}};
            clear_s  = br_bit & live_r;
        end else begin
            squash_s = {NSPEC{1'b0}};
            clear_s  = {NSPEC{1'b0}};
        end
    end

    // In-order prefix grant with slot, tag and spec-bit assignment per lane.
    always_comb begin
        logic [BUF_SIZE-1:0] free_v;
        logic [NSPEC-1:0]    used_v;
        logic [NSPEC-1:0]    taken_v;
        logic [NSPEC-1:0]    bit_v;
        logic [LW-1:0]       slot_v;
        logic [LW-1:0]       cnt_v;
        logic                blocked_v;
        logic                ok_v;
        free_v        = buf_free;
        used_v        = live_r;
        taken_v       = {NSPEC{1'b0}};
        cnt_v         = {LW{1'b0}};
        blocked_v     = reset | mispredict_s;
        grant         = {WIDTH{1'b0}};
        alloc_idx     = {(WIDTH*LW){1'b0}};
        alloc_tag     = {(WIDTH*LW){1'b0}};
        alloc_spectag = {(WIDTH*NSPEC){1'b0}};
        alloc_bits_s  = {NSPEC{1'b0}};
        for (int c = 0; c < NSPEC; c++) begin
            dep_new_s[c] = {NSPEC{1'b0}};
        end
        for (int j = 0; j < WIDTH; j++) begin
            bit_v  = lowest_clear_onehot(used_v);
            slot_v = lowest_free_slot(free_v);
            ok_v   = (|free_v) && (!in_is_branch[j] || (|bit_v));
            if (in_valid[j] && !blocked_v) begin
                if (ok_v) begin
                    grant[j]              = 1'b1;
                    alloc_idx[j*LW +: LW] = slot_v;
                    free_v[slot_v]        = 1'b0;
                    cnt_v                 = cnt_v + LW'(1);
                    alloc_tag[j*LW +: LW] = tag_r - cnt_v;
                    if (in_is_branch[j]) begin
                        // The new bit depends on every live bit and every bit taken by older lanes.
                        for (int c = 0; c < NSPEC; c++) begin
                            if (bit_v[c]) begin
                                dep_new_s[c] = live_r | taken_v;
                            end else begin
                                dep_new_s[c] = dep_new_s[c];
                            end
                        end
                        taken_v      = taken_v | bit_v;
                        used_v       = used_v | bit_v;
                        alloc_bits_s = alloc_bits_s | bit_v;
                    end else begin
                        taken_v = taken_v;
                    end
                    alloc_spectag[j*NSPEC +: NSPEC] = live_r | taken_v;
                end else begin
                    blocked_v = 1'b1;
                end
            end else begin
                blocked_v = blocked_v;
            end
        end
        next_tag_s = tag_r - cnt_v;
    end

    // State update: live pool, dependency rows and sequence tag register.
    always_ff @(posedge clk) begin
        if (reset) begin
            live_r <= {NSPEC{1'b0}};
            tag_r  <= {LW{1'b0}};
            for (int c = 0; c < NSPEC; c++) begin
                dep_r[c] <= {NSPEC{1'b0}};
            end
        end else begin
            live_r <= (live_r & ~clear_s) | alloc_bits_s;
            tag_r  <= next_tag_s;
            for (int c = 0; c < NSPEC; c++) begin
                if (alloc_bits_s[c]) begin
                    dep_r[c] <= dep_new_s[c] & ~clear_s;
                end else begin
                    dep_r[c] <= dep_r[c] & ~clear_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_alloc_nway.sv
// Directed bench for dispatch_alloc_nway (WIDTH=2, BUF_SIZE=16, NSPEC=6).
module tb_dispatch_alloc_nway;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_valid;
    logic [1:0]  in_is_branch;
    logic [15:0] buf_free;
    logic [1:0]  grant;
    logic [7:0]  alloc_idx;
    logic [7:0]  alloc_tag;
    logic [11:0] alloc_spectag;
    logic        br_valid;
    logic [5:0]  br_bit;
    logic        br_mispredict;
    logic [5:0]  squash_mask;
    logic [5:0]  live_mask;

    int total = 0;
    int bad   = 0;

    dispatch_alloc_nway #(.WIDTH(2), .BUF_SIZE(16), .BUF_SIZE_LOG(4), .NSPEC(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_is_branch(in_is_branch),
        .buf_free(buf_free), .grant(grant), .alloc_idx(alloc_idx), .alloc_tag(alloc_tag),
        .alloc_spectag(alloc_spectag), .br_valid(br_valid), .br_bit(br_bit),
        .br_mispredict(br_mispredict), .squash_mask(squash_mask), .live_mask(live_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs mid-low-phase and let combinational outputs settle.
    task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] b,
                         input logic [15:0] f, input logic bv, input logic [5:0] bb,
                         input logic bm);
        @(negedge clk);
        reset = rst; in_valid = v; in_is_branch = b; buf_free = f;
        br_valid = bv; br_bit = bb; br_mispredict = bm;
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 2'b00; in_is_branch = 2'b00; buf_free = 16'h0000;
        br_valid = 1'b0; br_bit = 6'd0; br_mispredict = 1'b0;

        // reset holds grant and squash low
        drive(1'b1, 2'b11, 2'b00, 16'hFFFF, 1'b1, 6'b000001, 1'b1);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_squash", 32'(squash_mask), 32'h0);
        drive(1'b0, 2'b00, 2'b00, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("rst_live", 32'(live_mask), 32'h0);

        // two plain lanes, full buffer
        drive(1'b0, 2'b11, 2'b00, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("t1_grant", 32'(grant), 32'h3);
        chk("t1_idx0", 32'(alloc_idx[3:0]), 32'h0);
        chk("t1_idx1", 32'(alloc_idx[7:4]), 32'h1);
        chk("t1_tag0", 32'(alloc_tag[3:0]), 32'hF);
        chk("t1_tag1", 32'(alloc_tag[7:4]), 32'hE);
        chk("t1_spec0", 32'(alloc_spectag[5:0]), 32'h0);
        drive(1'b0, 2'b11, 2'b00, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("t1b_tag0", 32'(alloc_tag[3:0]), 32'hD);
        chk("t1b_tag1", 32'(alloc_tag[7:4]), 32'hC);

        // single free slot
        drive(1'b0, 2'b11, 2'b00, 16'h0100, 1'b0, 6'd0, 1'b0);
        chk("t2_grant", 32'(grant), 32'h1);
        chk("t2_idx0", 32'(alloc_idx[3:0]), 32'h8);
        chk("t2_tag0", 32'(alloc_tag[3:0]), 32'hB);

        // buffer full: nothing granted, tag held
        drive(1'b0, 2'b11, 2'b00, 16'h0000, 1'b0, 6'd0, 1'b0);
        chk("full_grant", 32'(grant), 32'h0);

        // lane0 invalid does not block lane1
        drive(1'b0, 2'b10, 2'b00, 16'h00F0, 1'b0, 6'd0, 1'b0);
        chk("t6_grant", 32'(grant), 32'h2);
        chk("t6_idx1", 32'(alloc_idx[7:4]), 32'h4);
        chk("t6_tag1", 32'(alloc_tag[7:4]), 32'hA);

        // branch A takes bit0, branch B takes bit1
        drive(1'b0, 2'b01, 2'b01, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("t4a_grant", 32'(grant), 32'h1);
        chk("t4a_spec0", 32'(alloc_spectag[5:0]), 32'h01);
        chk("t4a_tag0", 32'(alloc_tag[3:0]), 32'h9);
        drive(1'b0, 2'b01, 2'b01, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("t4b_live", 32'(live_mask), 32'h01);
        chk("t4b_spec0", 32'(alloc_spectag[5:0]), 32'h03);
        chk("t4b_tag0", 32'(alloc_tag[3:0]), 32'h8);

        // mispredict A squashes A and B, blocks grants
        drive(1'b0, 2'b11, 2'b00, 16'hFFFF, 1'b1, 6'b000001, 1'b1);
        chk("t4_live_pre", 32'(live_mask), 32'h03);
        chk("t4_squash", 32'(squash_mask), 32'h03);
        chk("t4_grant", 32'(grant), 32'h0);

        // refill pool two bits per cycle
        drive(1'b0, 2'b11, 2'b11, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("t4_live_post", 32'(live_mask), 32'h00);
        chk("f1_grant", 32'(grant), 32'h3);
        chk("f1_spec0", 32'(alloc_spectag[5:0]), 32'h01);
        chk("f1_spec1", 32'(alloc_spectag[11:6]), 32'h03);
        chk("f1_tag0", 32'(alloc_tag[3:0]), 32'h7);
        chk("f1_tag1", 32'(alloc_tag[7:4]), 32'h6);
        drive(1'b0, 2'b11, 2'b11, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("f2_spec0", 32'(alloc_spectag[5:0]), 32'h07);
        chk("f2_spec1", 32'(alloc_spectag[11:6]), 32'h0F);
        chk("f2_tag1", 32'(alloc_tag[7:4]), 32'h4);
        drive(1'b0, 2'b11, 2'b11, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("f3_spec1", 32'(alloc_spectag[11:6]), 32'h3F);
        chk("f3_tag1", 32'(alloc_tag[7:4]), 32'h2);

        // correct resolve of bit0 with pool full: freed bit not reusable yet
        drive(1'b0, 2'b11, 2'b11, 16'hFFFF, 1'b1, 6'b000001, 1'b0);
        chk("t5_live", 32'(live_mask), 32'h3F);
        chk("t5_grant", 32'(grant), 32'h0);
        chk("t5_squash", 32'(squash_mask), 32'h0);

        // next cycle lane0 reuses bit0, lane1 blocks on empty pool
        drive(1'b0, 2'b11, 2'b11, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("t3_live_pre", 32'(live_mask), 32'h3E);
        chk("t3_grant", 32'(grant), 32'h1);
        chk("t3_spec0", 32'(alloc_spectag[5:0]), 32'h3F);
        chk("t3_tag0", 32'(alloc_tag[3:0]), 32'h1);

        // pool full: plain lane0 granted, branch lane1 blocked
        drive(1'b0, 2'b11, 2'b10, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("pf_live", 32'(live_mask), 32'h3F);
        chk("pf_grant", 32'(grant), 32'h1);
        chk("pf_tag0", 32'(alloc_tag[3:0]), 32'h0);
        chk("pf_spec0", 32'(alloc_spectag[5:0]), 32'h3F);

        // mispredict bit2 kills bits 3,4,5 and the reissued bit0
        drive(1'b0, 2'b11, 2'b00, 16'hFFFF, 1'b1, 6'b000100, 1'b1);
        chk("m2_squash", 32'(squash_mask), 32'h3D);
        chk("m2_grant", 32'(grant), 32'h0);

        // mispredict of a non-live bit is a no-op
        drive(1'b0, 2'b01, 2'b00, 16'hFFFF, 1'b1, 6'b000100, 1'b1);
        chk("m2_live_post", 32'(live_mask), 32'h02);
        chk("nl_squash", 32'(squash_mask), 32'h0);
        chk("nl_grant", 32'(grant), 32'h1);
        chk("nl_tag0", 32'(alloc_tag[3:0]), 32'hF);

        // reset mid-operation restores all state
        drive(1'b1, 2'b11, 2'b00, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("mr_grant", 32'(grant), 32'h0);
        drive(1'b0, 2'b01, 2'b00, 16'hFFFF, 1'b0, 6'd0, 1'b0);
        chk("mr_live", 32'(live_mask), 32'h0);
        chk("mr_tag0", 32'(alloc_tag[3:0]), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
